tl_ul_mem_slave: RTL and testbench

//   TileLink Uncached-Lightweight (TL-UL) manager/responder. It terminates Channel A requests

---
 rtl/tl_ul_mem_slave.sv | 179 +++++++++++++++++
 tb/tb_tl_ul_mem_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_mem_slave.sv
// TL-UL memory responder: terminates Channel A requests against a word-addressed on-chip
// array and returns responses on Channel D through a 2-entry FIFO (one request per cycle).
module tl_ul_mem_slave #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    SOURCE_WIDTH = 8,
    parameter int                    SINK_WIDTH   = 1,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    MEM_DEPTH    = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [2:0]                a_opcode,
    input  logic [2:0]                a_param,
    input  logic [SIZE_WIDTH-1:0]     a_size,
    input  logic [SOURCE_WIDTH-1:0]   a_source,
    input  logic [ADDR_WIDTH-1:0]     a_address,
    input  logic [DATA_WIDTH/8-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]     a_data,
    input  logic                      a_corrupt,
    input  logic                      a_valid,
    output logic                      a_ready,
    output logic [2:0]                d_opcode,
    output logic [1:0]                d_param,
    output logic [SIZE_WIDTH-1:0]     d_size,
    output logic [SOURCE_WIDTH-1:0]   d_source,
    output logic [SINK_WIDTH-1:0]     d_sink,
    output logic                      d_denied,
    output logic [DATA_WIDTH-1:0]     d_data,
    output logic                      d_corrupt,
    output logic                      d_valid,
    input  logic                      d_ready
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(MASK_WIDTH);
    localparam int IDX_BITS   = $clog2(MEM_DEPTH);
    localparam int MEM_AW     = OFF_BITS + IDX_BITS;
    localparam logic [SIZE_WIDTH-1:0] MAX_SIZE = SIZE_WIDTH'(OFF_BITS);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITHMETIC  = 3'd2;
    localparam logic [2:0] OP_LOGICAL     = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_INTENT      = 3'd5;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK        = 3'd2;

    typedef struct packed {
        logic [2:0]              opcode;
        logic [SIZE_WIDTH-1:0]   size;
        logic [SOURCE_WIDTH-1:0] source;
        logic                    denied;
        logic [DATA_WIDTH-1:0]   data;
        logic                    corrupt;
    } rsp_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    rsp_t                  r_fifo [2];
    logic [1:0]            r_count;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic                  r_active;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_in_range;
    logic                  w_size_ok;
    logic                  w_aligned;
    logic                  w_legal;
    logic                  w_write;
    logic [IDX_BITS-1:0]   w_idx;
    logic [ADDR_WIDTH-1:0] w_low_mask;
    rsp_t                  w_rsp;
    rsp_t                  w_head;
    logic                  w_unused;

    assign w_unused = ^a_param;

    // BASE_ADDR is aligned to the array size, so range reduces to an upper-bit match.
    assign w_in_range = (a_address[ADDR_WIDTH-1:MEM_AW] == BASE_ADDR[ADDR_WIDTH-1:MEM_AW]);
    assign w_size_ok  = (a_size <= MAX_SIZE);
    assign w_low_mask = ~({ADDR_WIDTH{1'b1}} << a_size);
    assign w_aligned  = ((a_address & w_low_mask) == '0);
    assign w_legal    = w_in_range && w_size_ok && w_aligned;
    assign w_idx      = a_address[MEM_AW-1:OFF_BITS];

    // a_ready depends only on registered state; it stays low while reset is asserted.
    assign a_ready  = r_active && (r_count != 2'd2);
    assign w_accept = a_valid && a_ready;
    assign d_valid  = (r_count != 2'd0);
    assign w_pop    = d_valid && d_ready;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_rsp        = '0;
        w_rsp.size   = a_size;
        w_rsp.source = a_source;
        w_write      = 1'b0;
        case (a_opcode)
            OP_GET: begin
                w_rsp.opcode = D_ACCESS_ACK_DATA;
                if (w_legal) begin
                    w_rsp.data = r_mem[w_idx];
                end else begin
                    w_rsp.denied  = 1'b1;
                    w_rsp.corrupt = 1'b1;
                end
            end
            OP_PUT_FULL, OP_PUT_PARTIAL: begin
                w_rsp.opcode = D_ACCESS_ACK;
                if (w_legal && !a_corrupt) begin
                    w_write = w_accept;
                end else begin
                    w_rsp.denied = 1'b1;
                end
            end
            OP_ARITHMETIC, OP_LOGICAL: begin
                w_rsp.opcode  = D_ACCESS_ACK_DATA;
                w_rsp.denied  = 1'b1;
                w_rsp.corrupt = 1'b1;
            end
            OP_INTENT: begin
                w_rsp.opcode = D_HINT_ACK;
            end
            default: begin
                w_rsp.opcode = D_ACCESS_ACK;
                w_rsp.denied = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_accept) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)    r_rd_ptr <= ~r_rd_ptr;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the memory and FIFO payload carry no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_accept) r_fifo[r_wr_ptr] <= w_rsp;
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (a_mask[i]) r_mem[w_idx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    assign w_head    = r_fifo[r_rd_ptr];
    assign d_opcode  = d_valid ? w_head.opcode  : '0;
    assign d_size    = d_valid ? w_head.size    : '0;
    assign d_source  = d_valid ? w_head.source  : '0;
    assign d_denied  = d_valid ? w_head.denied  : 1'b0;
    assign d_data    = d_valid ? w_head.data    : '0;
    assign d_corrupt = d_valid ? w_head.corrupt : 1'b0;
    assign d_param   = '0;
    assign d_sink    = '0;

endmodule

// File: tb/tb_tl_ul_mem_slave.sv
// Directed bench for tl_ul_mem_slave: a table of single-beat requests with hand-computed
// responses, then back-pressure and mid-traffic reset sequences.
module tb_tl_ul_mem_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
    logic        d_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tl_ul_mem_slave dut (
        .clk       (clk),
        .resetn    (resetn),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .a_corrupt (a_corrupt),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt),
        .d_valid   (d_valid),
        .d_ready   (d_ready)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        cor;
        logic [2:0]  e_op;
        logic        e_den;
        logic [31:0] e_data;
        logic        e_cor;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] size, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] data, input logic cor,
                                input logic [2:0] e_op, input logic e_den, input logic [31:0] e_data,
                                input logic e_cor);
        vec_t v;
        v.op = op; v.size = size; v.addr = addr; v.mask = mask; v.data = data; v.cor = cor;
        v.e_op = e_op; v.e_den = e_den; v.e_data = e_data; v.e_cor = e_cor;
        return v;
    endfunction

    task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [7:0] src,
                           input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                           input logic cor);
        a_opcode = op; a_size = size; a_source = src; a_address = addr;
        a_mask = mask; a_data = data; a_corrupt = cor; a_valid = 1'b1;
    endtask

    // Called at a negedge with an empty FIFO and d_ready=1.
    task automatic apply(input int i, input vec_t v);
        drive_a(v.op, v.size, 8'(i + 1), v.addr, v.mask, v.data, v.cor);
        check($sformatf("v%0d a_ready", i), 64'(a_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check($sformatf("v%0d d_valid", i),   64'(d_valid),   64'd1);
        check($sformatf("v%0d d_opcode", i),  64'(d_opcode),  64'(v.e_op));
        check($sformatf("v%0d d_denied", i),  64'(d_denied),  64'(v.e_den));
        check($sformatf("v%0d d_data", i),    64'(d_data),    64'(v.e_data));
        check($sformatf("v%0d d_corrupt", i), 64'(d_corrupt), 64'(v.e_cor));
        check($sformatf("v%0d d_source", i),  64'(d_source),  64'(i + 1));
        check($sformatf("v%0d d_size", i),    64'(d_size),    64'(v.size));
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d drained", i),   64'(d_valid),   64'd0);
    endtask

    initial begin
        resetn = 1'b0; a_valid = 1'b0; d_ready = 1'b1; a_param = 3'd0;
        a_opcode = 3'd0; a_size = 3'd0; a_source = 8'd0; a_address = 32'd0;
        a_mask = 4'd0; a_data = 32'd0; a_corrupt = 1'b0;

        // opcode, size, addr, mask, data, corrupt | d_opcode, denied, data, corrupt
        vecs.push_back(mk(3'd0, 3'd2, 32'h10,   4'hF, 32'hDEADBEEF, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(3'd4, 3'd2, 32'h10,   4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(3'd1, 3'd2, 32'h10,   4'h2, 32'h00005500, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(3'd4, 3'd2, 32'h10,   4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD55EF, 1'b0));
        vecs.push_back(mk(3'd0, 3'd2, 32'h0,    4'hF, 32'h12345678, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(3'd0, 3'd2, 32'hFFC,  4'hF, 32'hA5A5A5A5, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(3'd4, 3'd2, 32'hFFC,  4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hA5A5A5A5, 1'b0));
        vecs.push_back(mk(3'd4, 3'd2, 32'h1000, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0,        1'b1));
        vecs.push_back(mk(3'd4, 3'd2, 32'h2,    4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0,        1'b1));
        vecs.push_back(mk(3'd4, 3'd1, 32'h2,    4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'h12345678, 1'b0));
        vecs.push_back(mk(3'd4, 3'd0, 32'h13,   4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD55EF, 1'b0));
        vecs.push_back(mk(3'd4, 3'd3, 32'h10,   4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0,        1'b1));
        vecs.push_back(mk(3'd2, 3'd2, 32'h10,   4'hF, 32'hFFFFFFFF, 1'b0, 3'd1, 1'b1, 32'h0,        1'b1));
        vecs.push_back(mk(3'd3, 3'd2, 32'h0,    4'hF, 32'hFFFFFFFF, 1'b0, 3'd1, 1'b1, 32'h0,        1'b1));
        vecs.push_back(mk(3'd4, 3'd2, 32'h10,   4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD55EF, 1'b0));
        vecs.push_back(mk(3'd5, 3'd2, 32'h10,   4'hF, 32'h0,        1'b0, 3'd2, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(3'd6, 3'd2, 32'h10,   4'hF, 32'h0,        1'b0, 3'd0, 1'b1, 32'h0,        1'b0));
        vecs.push_back(mk(3'd7, 3'd2, 32'h10,   4'hF, 32'h0,        1'b0, 3'd0, 1'b1, 32'h0,        1'b0));
        vecs.push_back(mk(3'd0, 3'd2, 32'h10,   4'hF, 32'h0,        1'b1, 3'd0, 1'b1, 32'h0,        1'b0));
        vecs.push_back(mk(3'd0, 3'd2, 32'h1000, 4'hF, 32'h0,        1'b0, 3'd0, 1'b1, 32'h0,        1'b0));
        vecs.push_back(mk(3'd4, 3'd2, 32'h0,    4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'h12345678, 1'b0));
        vecs.push_back(mk(3'd4, 3'd2, 32'h10,   4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD55EF, 1'b0));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset a_ready", 64'(a_ready), 64'd0);
        check("reset d_valid", 64'(d_valid), 64'd0);
        check("reset d_opcode", 64'(d_opcode), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post-reset a_ready", 64'(a_ready), 64'd1);
        check("post-reset d_valid", 64'(d_valid), 64'd0);
        check("d_param", 64'(d_param), 64'd0);
        check("d_sink", 64'(d_sink), 64'd0);

        foreach (vecs[i]) apply(i, vecs[i]);

        // Back-pressure: three back-to-back Gets with d_ready low
        d_ready = 1'b0;
        drive_a(3'd4, 3'd2, 8'h40, 32'h10, 4'hF, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("bp first d_valid", 64'(d_valid), 64'd1);
        check("bp a_ready one queued", 64'(a_ready), 64'd1);
        drive_a(3'd4, 3'd2, 8'h41, 32'h0, 4'hF, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("bp a_ready full", 64'(a_ready), 64'd0);
        check("bp head source", 64'(d_source), 64'h40);
        drive_a(3'd4, 3'd2, 8'h42, 32'hFFC, 4'hF, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("bp a_ready held low", 64'(a_ready), 64'd0);
        check("bp stable source", 64'(d_source), 64'h40);
        check("bp stable data", 64'(d_data), 64'hDEAD55EF);
        check("bp stable valid", 64'(d_valid), 64'd1);
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp drain1 source", 64'(d_source), 64'h41);
        check("bp drain1 data", 64'(d_data), 64'h12345678);
        check("bp a_ready back", 64'(a_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check("bp drain2 source", 64'(d_source), 64'h42);
        check("bp drain2 data", 64'(d_data), 64'hA5A5A5A5);
        @(posedge clk);
        @(negedge clk);
        check("bp empty d_valid", 64'(d_valid), 64'd0);
        check("bp empty a_ready", 64'(a_ready), 64'd1);

        // Reset while two responses are queued
        d_ready = 1'b0;
        drive_a(3'd4, 3'd2, 8'h50, 32'h10, 4'hF, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive_a(3'd4, 3'd2, 8'h51, 32'h0, 4'hF, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check("rst queued full", 64'(a_ready), 64'd0);
        resetn = 1'b0;
        #1;
        check("rst mid d_valid", 64'(d_valid), 64'd0);
        check("rst mid a_ready", 64'(a_ready), 64'd0);
        check("rst mid d_source", 64'(d_source), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        d_ready = 1'b1;
        @(negedge clk);
        check("rst after d_valid", 64'(d_valid), 64'd0);
        check("rst after a_ready", 64'(a_ready), 64'd1);
        apply(100, mk(3'd4, 3'd2, 32'h10, 4'hF, 32'h0, 1'b0, 3'd1, 1'b0, 32'hDEAD55EF, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
